// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
// FSM encoding and default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fullAdder.sv
// Single-bit full adder cell.
// Combinational sum and carry of a, b and c_in.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c_in;
    assign carry = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one fullAdder cell, WIDTH cycles per sum.
// Operands shift out LSB first; sum bits shift in from the MSB.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_sum;
    logic             fa_carry;

    fullAdder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Next state, shift/accumulate datapath and result capture.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                s_sh_d  = {fa_sum, s_sh_q[WIDTH-1:1]};
                carry_d = fa_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = s_sh_d;
                    cout_d  = fa_carry;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign sum_out = sum_q;
    assign c_out   = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl.
// An 8-bit instance for directed cases, a 3-bit one for the sweep.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       c8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start3 = 1'b0;
    logic [2:0] a3 = '0;
    logic [2:0] b3 = '0;
    logic       c3 = 1'b0;
    logic       busy3;
    logic       done3;
    logic [2:0] sum3;
    logic       cout3;

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] prev8 = '0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .a_in    (a8),
        .b_in    (b8),
        .c_in    (c8),
        .busy    (busy8),
        .done    (done8),
        .sum_out (sum8),
        .c_out   (cout8)
    );

    serial_adder_ctrl #(.WIDTH(3)) u_dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start3),
        .a_in    (a3),
        .b_in    (b3),
        .c_in    (c3),
        .busy    (busy3),
        .done    (done3),
        .sum_out (sum3),
        .c_out   (cout3)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One 8-bit addition; optional stray start pulse at RUN cycle inj.
    task automatic op8(input string tag,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic c,
                       input logic [7:0] es,
                       input logic ec,
                       input int inj);
        int nb;
        int nd;
        logic [7:0] s;
        logic co;
        nb = 0;
        nd = 0;
        s = 'x;
        co = 1'bx;
        @(negedge clk);
        a8 = a;
        b8 = b;
        c8 = c;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        while (busy8 && nb < 20) begin
            nb++;
            if (done8) begin
                nd++;
                s = sum8;
                co = cout8;
            end
            if (nb == 2)
                check({tag, "_hold"}, {23'd0, cout8, sum8}, {23'd0, prev8});
            if (nb == inj) begin
                start8 = 1'b1;
                a8 = 8'hFF;
                b8 = 8'hFF;
                c8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        check({tag, "_busy"}, nb, 9);
        check({tag, "_done"}, nd, 1);
        check({tag, "_sum"}, {24'd0, s}, {24'd0, es});
        check({tag, "_cout"}, {31'd0, co}, {31'd0, ec});
        prev8 = {ec, es};
    endtask

    initial begin
        int gap;
        logic [3:0] exp3;

        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy8}, 0);
        check("rst_done", {31'd0, done8}, 0);
        check("rst_sum", {23'd0, cout8, sum8}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'd0, busy8}, 0);

        op8("t1", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, -1);
        op8("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
        op8("t3a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, -1);
        op8("t3b", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, -1);
        op8("t4", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3);
        repeat (3) @(negedge clk);
        check("t4_idle", {31'd0, busy8}, 0);

        @(negedge clk);
        a8 = 8'hFF;
        b8 = 8'hFF;
        c8 = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_run", {31'd0, busy8}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_busy", {31'd0, busy8}, 0);
        check("t5_done", {31'd0, done8}, 0);
        check("t5_res", {23'd0, cout8, sum8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_idle", {31'd0, busy8}, 0);
        check("t5_nodone", {31'd0, done8}, 0);
        prev8 = '0;
        op8("t5b", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, -1);

        @(negedge clk);
        start3 = 1'b1;
        gap = 0;
        for (int k = 0; k < 128; k++) begin
            a3 = k[2:0];
            b3 = k[5:3];
            c3 = k[6];
            exp3 = {1'b0, a3} + {1'b0, b3} + {3'd0, c3};
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!done3 && gap < 20);
            check("w3_done", {31'd0, done3}, 1);
            check("w3_res", {28'd0, cout3, sum3}, {28'd0, exp3});
            if (k > 0)
                check("w3_gap", gap, 5);
        end
        start3 = 1'b0;
        repeat (4) @(negedge clk);
        check("w3_idle", {31'd0, busy3}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
